// File: rtl/dmem_port.sv
// dmem_port: MEM-stage load/store unit with req/ack bus, stall and timeout; DMEM_ALIGN_CHECK_EN enables misalignment faults.
module dmem_port #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  MemRead,
  input  logic [1:0]  MemWrite,
  input  logic        LoadUnsigned,
  input  logic [31:0] Aluout,
  input  logic [31:0] busB,
  output logic        stall,
  output logic [31:0] radata,
  output logic        mem_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] cnt;
  logic [1:0] size, lsize, laddr;
  logic lunsigned, req, bad, mis, tmo;
  logic [3:0] be;
  logic [31:0] wdata, ldata;
  logic [7:0] b_v;
  logic [15:0] h_v;
  assign req = |MemRead || |MemWrite;
  assign size = MemRead | MemWrite;
`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = (size == 2'b10 && Aluout[0]) || (size == 2'b11 && |Aluout[1:0]);
`else
  assign mis = 1'b0;
`endif
  assign bad = (|MemRead && |MemWrite) || mis;
  assign tmo = cnt == 8'(MAX_WAIT - 1);
  assign stall = reset && (state == BUSY || (state == IDLE && req));
  assign be = size == 2'b01 ? 4'b0001 << Aluout[1:0] :
              size == 2'b10 ? (Aluout[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata = ~|MemWrite ? 32'h0 :
                 size == 2'b01 ? {4{busB[7:0]}} :
                 size == 2'b10 ? {2{busB[15:0]}} : busB;
  // Move the addressed lane(s) down to bit 0 before extension
  assign b_v = bus_rdata[{laddr, 3'b000} +: 8];
  assign h_v = laddr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  assign ldata = lsize == 2'b01 ? {{24{b_v[7] & ~lunsigned}}, b_v} :
                 lsize == 2'b10 ? {{16{h_v[15] & ~lunsigned}}, h_v} : bus_rdata;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = req ? (bad ? DONE : BUSY) : IDLE;
      BUSY:    state_nx = (bus_ack || tmo) ? DONE : BUSY;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      radata    <= '0;
      mem_err   <= 1'b0;
      lsize     <= '0;
      laddr     <= '0;
      lunsigned <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req && bad) begin
            mem_err <= 1'b1;
            radata  <= '0;
          end else if (req) begin
            bus_req   <= 1'b1;
            bus_we    <= |MemWrite;
            bus_addr  <= {Aluout[31:2], 2'b00};
            bus_be    <= be;
            bus_wdata <= wdata;
            lsize     <= size;
            laddr     <= Aluout[1:0];
            lunsigned <= LoadUnsigned;
            cnt       <= '0;
          end
        end
        BUSY: begin
          if (bus_ack) begin
            radata  <= bus_we ? 32'h0 : ldata;
            mem_err <= 1'b0;
            bus_req <= 1'b0;
          end else if (tmo) begin
            radata  <= '0;
            mem_err <= 1'b1;
            bus_req <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: mem_err <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_port.sv
// tb_dmem_port: scoreboard bench for dmem_port; access results are queued at issue and checked in DONE.
module tb_dmem_port;
  logic        clk = 0, reset = 0;
  logic [1:0]  MemRead = 0, MemWrite = 0;
  logic        LoadUnsigned = 0;
  logic [31:0] Aluout = 0, busB = 0;
  logic        stall, mem_err, bus_req, bus_we, bus_ack = 0;
  logic [31:0] radata, bus_addr, bus_wdata, bus_rdata = 0;
  logic [3:0]  bus_be;

  dmem_port #(.MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .LoadUnsigned(LoadUnsigned), .Aluout(Aluout), .busB(busB), .stall(stall),
    .radata(radata), .mem_err(mem_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] rd; logic err;} exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, failures = 0;
  int obs_stall, obs_req;
  logic obs_unstable, obs_we, obs_err;
  logic [31:0] obs_rd, obs_addr, obs_wdata;
  logic [3:0] obs_be;

  function automatic logic [31:0] model_load(logic [31:0] rd, logic [31:0] a, logic [1:0] sz, logic lu);
    logic [31:0] s;
    s = rd >> (8 * a[1:0]);
    if (sz == 2'b01) return lu ? (s & 32'hFF) : 32'(signed'(s[7:0]));
    s = rd >> (16 * a[1]);
    if (sz == 2'b10) return lu ? (s & 32'hFFFF) : 32'(signed'(s[15:0]));
    return rd;
  endfunction

  // Drives one access as the pipeline would (inputs held while stalled) and acts as the bus slave.
  task automatic do_access(input logic [1:0] mr, input logic [1:0] mw, input logic lu,
                           input logic [31:0] addr, input logic [31:0] bdata,
                           input logic [31:0] rdata, input int ack_at);
    bit done = 0;
    obs_stall = 0; obs_req = 0; obs_unstable = 0; obs_rd = 'x; obs_err = 'x;
    obs_addr = 'x; obs_be = 'x; obs_we = 'x; obs_wdata = 'x;
    MemRead = mr; MemWrite = mw; LoadUnsigned = lu; Aluout = addr; busB = bdata;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (bus_req) begin
        obs_req++;
        if (obs_req == 1) begin
          obs_addr = bus_addr; obs_be = bus_be; obs_we = bus_we; obs_wdata = bus_wdata;
        end else if ({bus_addr, bus_be, bus_we, bus_wdata} !== {obs_addr, obs_be, obs_we, obs_wdata})
          obs_unstable = 1;
        bus_ack = (obs_req == ack_at);
        bus_rdata = bus_ack ? rdata : 32'h0;
      end else bus_ack = 0;
      if (stall) obs_stall++;
      else begin
        obs_rd = radata; obs_err = mem_err; done = 1;
        MemRead = 0; MemWrite = 0;
      end
      @(negedge clk);
    end
    bus_ack = 0;
  endtask

  task automatic test_reset;
    reset = 0; MemRead = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, radata, mem_err} !== 103'h0) begin
      failures++;
      $display("FAIL reset_outputs req=%b we=%b addr=%h be=%b wdata=%h rd=%h err=%b exp all 0",
               bus_req, bus_we, bus_addr, bus_be, bus_wdata, radata, mem_err);
    end
    MemRead = 0; reset = 1;
    @(negedge clk);
  endtask

  task automatic test_no_access;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL nomem_stall got=%b exp=0", stall); end
    @(negedge clk); #1;
    checks++;
    if (bus_req !== 1'b0) begin failures++; $display("FAIL nomem_req got=%b exp=0", bus_req); end
    @(negedge clk);
  endtask

  task automatic test_word_load;
    sb.push_back('{32'hDEADBEEF, 1'b0});
    do_access(2'b11, 2'b00, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    e = sb.pop_front();
    checks++;
    if (obs_rd !== e.rd || obs_err !== e.err) begin
      failures++; $display("FAIL word_load rd=%h err=%b exp rd=%h err=%b", obs_rd, obs_err, e.rd, e.err);
    end
    checks++;
    if (obs_be !== 4'b1111 || obs_addr !== 32'h100 || obs_we !== 1'b0 || obs_wdata !== 32'h0) begin
      failures++; $display("FAIL word_load_bus be=%b addr=%h we=%b wd=%h exp 1111 100 0 0", obs_be, obs_addr, obs_we, obs_wdata);
    end
    checks++;
    if (obs_stall != 2 || obs_req != 1) begin
      failures++; $display("FAIL word_load_timing stall=%0d req=%0d exp 2 1", obs_stall, obs_req);
    end
  endtask

  task automatic test_byte_loads;
    for (int u = 0; u < 2; u++) begin
      sb.push_back('{u ? 32'h00000080 : 32'hFFFFFF80, 1'b0});
      do_access(2'b01, 2'b00, u[0], 32'h203, 32'h0, 32'h80FF0000, 1);
      e = sb.pop_front();
      checks++;
      if (obs_rd !== e.rd || obs_err !== e.err) begin
        failures++; $display("FAIL byte_load lu=%0d rd=%h err=%b exp rd=%h err=%b", u, obs_rd, obs_err, e.rd, e.err);
      end
      checks++;
      if (obs_be !== 4'b1000 || obs_addr !== 32'h200) begin
        failures++; $display("FAIL byte_load_be be=%b addr=%h exp 1000 200", obs_be, obs_addr);
      end
    end
  endtask

  task automatic test_half_store;
    sb.push_back('{32'h0, 1'b0});
    do_access(2'b00, 2'b10, 0, 32'h302, 32'h1234ABCD, 32'hFFFFFFFF, 4);
    e = sb.pop_front();
    checks++;
    if (obs_rd !== e.rd || obs_err !== e.err) begin
      failures++; $display("FAIL half_store rd=%h err=%b exp rd=%h err=%b", obs_rd, obs_err, e.rd, e.err);
    end
    checks++;
    if (obs_we !== 1'b1 || obs_be !== 4'b1100 || obs_wdata !== 32'hABCDABCD || obs_addr !== 32'h300) begin
      failures++; $display("FAIL half_store_bus we=%b be=%b wd=%h addr=%h exp 1 1100 abcdabcd 300", obs_we, obs_be, obs_wdata, obs_addr);
    end
    checks++;
    if (obs_stall != 5 || obs_req != 4 || obs_unstable) begin
      failures++; $display("FAIL half_store_timing stall=%0d req=%0d unstable=%b exp 5 4 0", obs_stall, obs_req, obs_unstable);
    end
  endtask

  task automatic test_timeout;
    sb.push_back('{32'h0, 1'b1});
    do_access(2'b11, 2'b00, 0, 32'h400, 32'h0, 32'h0, 0);
    e = sb.pop_front();
    checks++;
    if (obs_rd !== e.rd || obs_err !== e.err) begin
      failures++; $display("FAIL timeout rd=%h err=%b exp rd=%h err=%b", obs_rd, obs_err, e.rd, e.err);
    end
    checks++;
    if (obs_req != 15 || obs_stall != 16) begin
      failures++; $display("FAIL timeout_len req=%0d stall=%0d exp 15 16", obs_req, obs_stall);
    end
    bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus_ack = 0; #1;
    checks++;
    if (bus_req !== 1'b0 || stall !== 1'b0 || mem_err !== 1'b0 || radata !== 32'h0) begin
      failures++; $display("FAIL late_ack req=%b stall=%b err=%b rd=%h exp 0 0 0 0", bus_req, stall, mem_err, radata);
    end
    @(negedge clk);
  endtask

  task automatic test_misalign;
`ifdef DMEM_ALIGN_CHECK_EN
    sb.push_back('{32'h0, 1'b1});
`else
    sb.push_back('{32'h11223344, 1'b0});
`endif
    do_access(2'b11, 2'b00, 0, 32'h101, 32'h0, 32'h11223344, 1);
    e = sb.pop_front();
    checks++;
    if (obs_rd !== e.rd || obs_err !== e.err) begin
      failures++; $display("FAIL misalign rd=%h err=%b exp rd=%h err=%b", obs_rd, obs_err, e.rd, e.err);
    end
    checks++;
`ifdef DMEM_ALIGN_CHECK_EN
    if (obs_req != 0 || obs_stall != 1) begin
      failures++; $display("FAIL misalign_bus req=%0d stall=%0d exp 0 1", obs_req, obs_stall);
    end
`else
    if (obs_addr !== 32'h100 || obs_be !== 4'b1111 || obs_stall != 2) begin
      failures++; $display("FAIL misalign_bus addr=%h be=%b stall=%0d exp 100 1111 2", obs_addr, obs_be, obs_stall);
    end
`endif
  endtask

  task automatic test_reset_mid_busy;
    MemRead = 2'b11; Aluout = 32'h500;
    repeat (4) @(negedge clk);
    reset = 0;
    @(negedge clk); #1;
    checks++;
    if (bus_req !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL midreset req=%b stall=%b exp 0 0", bus_req, stall);
    end
    checks++;
    if ({bus_we, bus_addr, bus_be, bus_wdata, radata, mem_err} !== 102'h0) begin
      failures++; $display("FAIL midreset_outputs we=%b addr=%h be=%b wd=%h rd=%h err=%b exp all 0",
                           bus_we, bus_addr, bus_be, bus_wdata, radata, mem_err);
    end
    MemRead = 0; reset = 1; bus_ack = 1;
    @(negedge clk);
    bus_ack = 0; #1;
    checks++;
    if (bus_req !== 1'b0 || stall !== 1'b0 || mem_err !== 1'b0) begin
      failures++; $display("FAIL midreset_lateack req=%b stall=%b err=%b exp 0 0 0", bus_req, stall, mem_err);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    sb.push_back('{32'h0, 1'b1});
    do_access(2'b01, 2'b01, 0, 32'h600, 32'h55, 32'h0, 1);
    e = sb.pop_front();
    checks++;
    if (obs_rd !== e.rd || obs_err !== e.err) begin
      failures++; $display("FAIL illegal rd=%h err=%b exp rd=%h err=%b", obs_rd, obs_err, e.rd, e.err);
    end
    checks++;
    if (obs_req != 0 || obs_stall != 1) begin
      failures++; $display("FAIL illegal_bus req=%0d stall=%0d exp 0 1", obs_req, obs_stall);
    end
    #1;
    checks++;
    if (mem_err !== 1'b0) begin failures++; $display("FAIL err_one_cycle got=%b exp=0", mem_err); end
  endtask

  task automatic test_random_loads;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] sz;
      logic [31:0] a, rd;
      logic [3:0] xbe;
      logic lu;
      sz = 2'($urandom_range(1, 3));
      a = $urandom & ~32'h3;
      a[1:0] = sz == 2'b01 ? 2'($urandom) : sz == 2'b10 ? {1'($urandom), 1'b0} : 2'b00;
      rd = $urandom; lu = 1'($urandom);
      xbe = sz == 2'b11 ? 4'hF : sz == 2'b10 ? (a[1] ? 4'hC : 4'h3) : 4'b0001 << a[1:0];
      sb.push_back('{model_load(rd, a, sz, lu), 1'b0});
      do_access(sz, 2'b00, lu, a, 32'h0, rd, $urandom_range(1, 3));
      e = sb.pop_front();
      checks++;
      if (obs_rd !== e.rd || obs_err !== e.err || obs_be !== xbe) begin
        failures++; $display("FAIL rand_load sz=%0d a=%h rd=%h err=%b be=%b exp rd=%h err=%b be=%b",
                             sz, a, obs_rd, obs_err, obs_be, e.rd, e.err, xbe);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_no_access;
    test_word_load;
    test_byte_loads;
    test_half_store;
    test_timeout;
    test_misalign;
    test_reset_mid_busy;
    test_illegal;
    test_random_loads;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_port.md
# dmem_port

Load/store access unit sitting in the MEM stage between the EX/MEM pipeline register and the data-memory bus. It turns the 2-bit MemRead/MemWrite size codes, the ALU address and the store data into a req/ack bus transaction with byte enables. It stalls the pipeline until the bus responds, then presents the aligned, extended load result on `radata` for the MEM/WB register to capture.

## Interface
- `MAX_WAIT`, 15: bus cycles allowed without `bus_ack` before the access is aborted (1..255).
- `clk`  input  1  pipeline clock; all state updates on the rising edge.
- `reset`  input  1  synchronous reset, active-low.
- `MemRead`  input  2  load size: 00 none, 01 byte, 10 halfword, 11 word.
- `MemWrite`  input  2  store size, same encoding.
- `LoadUnsigned`  input  1  1 = zero-extend byte/half loads, 0 = sign-extend.
- `Aluout`  input  32  effective byte address.
- `busB`  input  32  store data (right-justified).
- `stall`  output  1  holds PC, IF/ID, ID/EX and EX/MEM, and bubbles MEM/WB; combinational.
- `radata`  output  32  load result, registered.
- `mem_err`  output  1  one-cycle error flag, registered.
- `bus_req`  output  1  transaction request, registered.
- `bus_we`  output  1  1 = write.
- `bus_addr`  output  32  word address, `{Aluout[31:2],2'b00}`.
- `bus_be`  output  4  byte enables, bit i = byte lane i (little-endian).
- `bus_wdata`  output  32  lane-replicated store data.
- `bus_ack`  input  1  completion, one cycle; sampled only in BUSY.
- `bus_rdata`  input  32  read data, valid in the `bus_ack` cycle.

## Operation
- States: IDLE, BUSY, DONE. Reset (`reset`=0): state IDLE, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0, `radata`=0, `mem_err`=0, wait counter=0. `stall` is forced 0 while `reset`=0.
- Access request = `MemRead`!=0 or `MemWrite`!=0. If both are nonzero, the request is illegal. The unit goes IDLE→DONE with `mem_err`=1, `radata`=0 and no bus cycle.
- IDLE with legal request: `stall`=1. On the next edge, latch the address, size, direction and LoadUnsigned. Drive the bus fields and `bus_req`=1, then go to BUSY.
- BUSY: `stall`=1 and `bus_req` is held with stable fields. Each cycle without ack increments the counter.
  - `bus_ack`=1: capture the extended load data into `radata` (writes capture 0), `mem_err`=0, drop `bus_req`, go to DONE.
  - Counter reaches MAX_WAIT with no ack: drop `bus_req`, `radata`=0, `mem_err`=1, go to DONE.
  - An ack in the same cycle the counter hits MAX_WAIT counts as success.
- DONE: `stall`=0, so the pipeline advances at this edge and MEM/WB captures `radata`. `mem_err` is valid this cycle only. New requests are ignored and the unit returns to IDLE.
- Store lanes:
  - Byte: `bus_be`=1<<addr[1:0], `bus_wdata`={4{busB[7:0]}}.
  - Half: `bus_be`=addr[1]?1100:0011, `bus_wdata`={2{busB[15:0]}}.
  - Word: `bus_be`=1111, `bus_wdata`=busB.
- Loads drive `bus_be` by the same rule and `bus_wdata`=0. The selected lane(s) of `bus_rdata` are shifted to bit 0 and then sign- or zero-extended.
- `bus_ack` seen in IDLE or DONE is ignored.

## Timing
- Latency: request in cycle 0 (IDLE); `bus_req` high in cycle 1. With ack in cycle n (n≥1), DONE is cycle n+1. `stall` is high for cycles 0..n.
- Minimum access: 3 cycles, with 2 stall cycles.
- Non-memory instructions pass with `stall`=0 and zero added latency.
- Reset mid-BUSY: at the reset edge `bus_req` drops and the state returns to IDLE. The outstanding transaction is abandoned, and any late ack is ignored.
- `stall` depends combinationally on the state, `MemRead`/`MemWrite` and `reset` only, never on `bus_ack`.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined: a misaligned access (half with addr[0]=1, word with addr[1:0]!=0) issues no bus cycle. The unit goes IDLE→DONE with `mem_err`=1 and `radata`=0, giving 1 stall cycle.
- Undefined: misalignment is not detected. Half uses only addr[1], word ignores addr[1:0], and `mem_err` arises only from timeout or an illegal request.

## Test plan
- Word load: Aluout=0x100, MemRead=11, ack in the first BUSY cycle with rdata=0xDEADBEEF. Expect `bus_be`=1111, `stall` high for 2 cycles, `radata`=0xDEADBEEF in DONE, `mem_err`=0.
- Byte loads: Aluout=0x203, rdata=0x80FF_0000.
  - LoadUnsigned=0: expect `bus_be`=1000 and `radata`=0xFFFFFF80.
  - LoadUnsigned=1: expect `radata`=0x00000080.
- Half store: Aluout=0x302, busB=0x1234ABCD, ack delayed 4 cycles. Expect `bus_we`=1, `bus_be`=1100, `bus_wdata`=0xABCDABCD, `stall` high for 5 cycles, and `bus_req` fields stable throughout.
- Timeout: MAX_WAIT=15, load with no ack. Expect `bus_req` for exactly 15 cycles, then DONE with `mem_err`=1 and `radata`=0. A late ack in IDLE is ignored.
- Misalignment with `DMEM_ALIGN_CHECK_EN`: word load at 0x101. Expect no `bus_req`, 1 stall cycle and `mem_err`=1. Without the macro, expect a bus access at `bus_addr`=0x100 with `bus_be`=1111.
- Reset mid-BUSY and illegal request:
  - `reset`=0 in cycle 3 of BUSY: `bus_req`=0 and `stall`=0 next cycle, all outputs at reset values.
  - MemRead=01 with MemWrite=01: expect `mem_err`=1 and no bus cycle.
